// File: rtl/vga_frame_capture_if.sv
// VGA capture bus: incoming 4:4:4 video stream and the outgoing frame-buffer write port.
// master drives the video and consumes writes; slave is the capture block.
interface vga_frame_capture_if #(
  parameter int unsigned ADDR_W = 19
);
  logic              vga_hsync;
  logic              vga_vsync;
  logic [3:0]        vga_red;
  logic [3:0]        vga_green;
  logic [3:0]        vga_blue;
  logic              pix_we;
  logic [ADDR_W-1:0] pix_waddr;
  logic [11:0]       pix_wdata;
  logic              frame_done;
  logic              frame_err;

  modport master (
    output vga_hsync, vga_vsync, vga_red, vga_green, vga_blue,
    input  pix_we, pix_waddr, pix_wdata, frame_done, frame_err
  );

  modport slave (
    input  vga_hsync, vga_vsync, vga_red, vga_green, vga_blue,
    output pix_we, pix_waddr, pix_wdata, frame_done, frame_err
  );
endinterface

// File: rtl/vga_frame_capture.sv
// Captures whole VGA frames into a linear frame buffer: locates the active window from
// sync edges and back-porch counts, emits one {R,G,B} write per active pixel.
module vga_frame_capture #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                capture_en,
  vga_frame_capture_if.slave  bus,
  output logic                busy
);

  localparam logic [10:0] PxFirst = 11'(H_BACK);
  localparam logic [10:0] PxLast  = 11'(H_BACK + H_ACTIVE - 1);
  localparam logic [9:0]  LnFirst = 10'(V_BACK);
  localparam logic [9:0]  LnLast  = 10'(V_BACK + V_ACTIVE - 1);

  typedef enum logic [1:0] {StIdle, StArmed, StCapture} state_e;

  state_e            state_q, state_d;
  logic              hs_q, hs_prev_q, vs_q, vs_prev_q;
  logic [11:0]       rgb_q;
  logic [10:0]       px_q, px_d;
  logic [9:0]        ln_q, ln_d;
  logic              started_q, started_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [11:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              hs_rise, vs_rise, active, last_px;

  // Input stage; sync history idles high so reset release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q      <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_q      <= 1'b1;
      vs_prev_q <= 1'b1;
      rgb_q     <= '0;
    end else begin
      hs_q      <= bus.vga_hsync;
      hs_prev_q <= hs_q;
      vs_q      <= bus.vga_vsync;
      vs_prev_q <= vs_q;
      rgb_q     <= {bus.vga_red, bus.vga_green, bus.vga_blue};
    end
  end

  assign hs_rise = hs_q & ~hs_prev_q;
  assign vs_rise = vs_q & ~vs_prev_q;

  // Position of the sample currently held in the input stage.
  always_comb begin
    px_d      = hs_rise ? '0 : ((px_q != 11'h7ff) ? px_q + 11'd1 : px_q);
    ln_d      = ln_q;
    started_d = started_q;
    if (vs_rise) begin
      ln_d      = '0;
      started_d = 1'b0;
    end else if (hs_rise) begin
      if (!started_q) begin
        // First hsync edge after vsync opens line 0.
        ln_d      = '0;
        started_d = 1'b1;
      end else if (ln_q != 10'h3ff) begin
        ln_d = ln_q + 10'd1;
      end
    end
  end

  assign active  = started_d && (px_d >= PxFirst) && (px_d <= PxLast)
                   && (ln_d >= LnFirst) && (ln_d <= LnLast);
  assign last_px = active && (px_d == PxLast) && (ln_d == LnLast);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (capture_en) state_d = StArmed;
      end
      StArmed: begin
        if (!capture_en) begin
          state_d = StIdle;
        end else if (vs_rise) begin
          state_d = StCapture;
          addr_d  = '0;
        end
      end
      StCapture: begin
        if (vs_rise) begin
          // Frame cut short: restart on this vsync if still enabled.
          err_d   = 1'b1;
          addr_d  = '0;
          if (!capture_en) state_d = StIdle;
        end else if (active) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = rgb_q;
          addr_d  = addr_q + 1'b1;
          if (last_px) begin
            done_d  = 1'b1;
            state_d = capture_en ? StArmed : StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StCapture) || done_d || err_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      px_q      <= '0;
      ln_q      <= '0;
      started_q <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      px_q      <= px_d;
      ln_q      <= ln_d;
      started_q <= started_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.pix_we     = we_q;
  assign bus.pix_waddr  = waddr_q;
  assign bus.pix_wdata  = wdata_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture with an 8x4 active window (H_BACK=2, V_BACK=1).
module tb_vga_frame_capture;

  localparam int HA = 8;
  localparam int HB = 2;
  localparam int VA = 4;
  localparam int VB = 1;
  localparam int AW = 5;
  localparam int HI_LEN = 12;

  logic clk = 1'b0;
  logic rst_n;
  logic capture_en;
  logic busy;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  vga_frame_capture_if #(.ADDR_W(AW)) vif ();

  vga_frame_capture #(
    .H_ACTIVE(HA), .H_BACK(HB), .V_ACTIVE(VA), .V_BACK(VB), .ADDR_W(AW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture_en(capture_en),
    .bus       (vif),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled mid-cycle.
  logic [AW-1:0] mon_addr [64];
  logic [11:0]   mon_data [64];
  int wr_cnt, done_cnt, err_cnt, both_cnt, busy_cnt, done_no_we;
  int first_we_cyc, first_active_cyc;
  logic [AW-1:0] done_addr;

  always @(negedge clk) begin
    if (vif.pix_we) begin
      if (wr_cnt < 64) begin
        mon_addr[wr_cnt] = vif.pix_waddr;
        mon_data[wr_cnt] = vif.pix_wdata;
      end
      if (wr_cnt == 0) first_we_cyc = cyc;
      wr_cnt++;
    end
    if (vif.frame_done) begin
      done_cnt++;
      done_addr = vif.pix_waddr;
      if (!vif.pix_we) done_no_we++;
    end
    if (vif.frame_err) err_cnt++;
    if (vif.frame_done && vif.frame_err) both_cnt++;
    if (busy) busy_cnt++;
  end

  function automatic logic [11:0] exp_data(input int n);
    logic [3:0] x, y;
    x = 4'(n % HA);
    y = 4'(n / HA);
    return {x, y, 4'ha};
  endfunction

  task automatic clear_mon();
    for (int i = 0; i < 64; i++) begin
      mon_addr[i] = 'x;
      mon_data[i] = 'x;
    end
    wr_cnt = 0; done_cnt = 0; err_cnt = 0; both_cnt = 0; busy_cnt = 0; done_no_we = 0;
    first_we_cyc = -1; first_active_cyc = -1; done_addr = '0;
  endtask

  task automatic drive(input logic hs, input logic vs, input logic [11:0] rgb);
    @(posedge clk);
    #1;
    vif.vga_hsync = hs;
    vif.vga_vsync = vs;
    {vif.vga_red, vif.vga_green, vif.vga_blue} = rgb;
  endtask

  // Pixel colour encodes {x, y, A}; y is the active-line number (may be out of window).
  task automatic drive_line(input int y, input int first_p, input int last_p);
    if (first_p == 0) begin
      drive(1'b0, 1'b1, 12'h000);
      drive(1'b0, 1'b1, 12'h000);
    end
    for (int p = first_p; p <= last_p; p++) begin
      drive(1'b1, 1'b1, {4'(p - HB), 4'(y), 4'ha});
      if (y == 0 && p == HB && first_active_cyc < 0) first_active_cyc = cyc;
    end
  endtask

  task automatic vsync_pulse();
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 12'h000);
  endtask

  task automatic drive_frame();
    vsync_pulse();
    for (int n = 0; n < VB + VA + 1; n++) drive_line(n - VB, 0, HI_LEN - 1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 12'h000);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    capture_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'($urandom), 1'($urandom), 12'($urandom));
      capture_en = 1'($urandom);
    end
    checks++;
    if (vif.pix_we !== 1'b0 || vif.frame_done !== 1'b0 || vif.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses we=%b done=%b err=%b required 0 0 0",
               vif.pix_we, vif.frame_done, vif.frame_err);
    end
    checks++;
    if (vif.pix_waddr !== '0 || vif.pix_wdata !== 12'h000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_data waddr=%h wdata=%h busy=%b required 0 0 0",
               vif.pix_waddr, vif.pix_wdata, busy);
    end
    capture_en = 1'b0;
    drive(1'b1, 1'b1, 12'h000);
    rst_n = 1'b1;
    clear_mon();
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 12'h000);
    checks++;
    if (wr_cnt + done_cnt + err_cnt + busy_cnt !== 0) begin
      errors++;
      $display("FAIL reset_release writes=%0d done=%0d err=%0d busy_cycles=%0d required all 0",
               wr_cnt, done_cnt, err_cnt, busy_cnt);
    end
  endtask

  task automatic test_full_frame();
    capture_en = 1'b1;
    drive(1'b1, 1'b1, 12'h000);
    clear_mon();
    drive_frame();
    checks++;
    if (wr_cnt !== 32) begin
      errors++;
      $display("FAIL full_frame_count got %0d required 32", wr_cnt);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (mon_addr[i] !== AW'(i) || mon_data[i] !== exp_data(i)) begin
        errors++;
        $display("FAIL full_frame_write%0d addr=%h data=%h required addr=%h data=%h",
                 i, mon_addr[i], mon_data[i], AW'(i), exp_data(i));
      end
    end
    checks++;
    if (done_cnt !== 1 || done_addr !== AW'(31) || done_no_we !== 0) begin
      errors++;
      $display("FAIL full_frame_done count=%0d addr=%0d unpaired=%0d required 1 31 0",
               done_cnt, done_addr, done_no_we);
    end
    checks++;
    if (first_we_cyc - first_active_cyc !== 2) begin
      errors++;
      $display("FAIL full_frame_latency got %0d edges required 2",
               first_we_cyc - first_active_cyc);
    end
    checks++;
    if (err_cnt !== 0 || busy !== 1'b0 || busy_cnt == 0) begin
      errors++;
      $display("FAIL full_frame_status err=%0d busy=%b busy_cycles=%0d required 0 0 nonzero",
               err_cnt, busy, busy_cnt);
    end
  endtask

  task automatic test_capture_disabled();
    capture_en = 1'b0;
    clear_mon();
    drive_frame();
    drive_frame();
    checks++;
    if (wr_cnt !== 0 || busy_cnt !== 0 || done_cnt + err_cnt !== 0) begin
      errors++;
      $display("FAIL disabled writes=%0d busy_cycles=%0d pulses=%0d required 0 0 0",
               wr_cnt, busy_cnt, done_cnt + err_cnt);
    end
  endtask

  task automatic test_late_enable();
    clear_mon();
    vsync_pulse();
    drive_line(-1, 0, HI_LEN - 1);
    drive_line(0, 0, HI_LEN - 1);
    drive_line(1, 0, 4);
    capture_en = 1'b1;
    drive_line(1, 5, HI_LEN - 1);
    for (int n = 3; n < VB + VA + 1; n++) drive_line(n - VB, 0, HI_LEN - 1);
    checks++;
    if (wr_cnt !== 0 || busy_cnt !== 0) begin
      errors++;
      $display("FAIL late_enable_early writes=%0d busy_cycles=%0d required 0 0",
               wr_cnt, busy_cnt);
    end
    drive_frame();
    checks++;
    if (wr_cnt !== 32 || done_cnt !== 1 || done_addr !== AW'(31)) begin
      errors++;
      $display("FAIL late_enable_frame writes=%0d done=%0d addr=%0d required 32 1 31",
               wr_cnt, done_cnt, done_addr);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (mon_addr[i] !== AW'(i) || mon_data[i] !== exp_data(i)) begin
        errors++;
        $display("FAIL late_enable_write%0d addr=%h data=%h required addr=%h data=%h",
                 i, mon_addr[i], mon_data[i], AW'(i), exp_data(i));
      end
    end
  endtask

  task automatic test_truncated_frame();
    clear_mon();
    vsync_pulse();
    for (int n = 0; n < VB + 2; n++) drive_line(n - VB, 0, HI_LEN - 1);
    drive_frame();
    checks++;
    if (err_cnt !== 1 || done_cnt !== 1 || both_cnt !== 0) begin
      errors++;
      $display("FAIL truncated_pulses err=%0d done=%0d both=%0d required 1 1 0",
               err_cnt, done_cnt, both_cnt);
    end
    checks++;
    if (wr_cnt !== 48 || done_addr !== AW'(31)) begin
      errors++;
      $display("FAIL truncated_count writes=%0d done_addr=%0d required 48 31", wr_cnt, done_addr);
    end
    for (int i = 0; i < 48; i++) begin
      checks++;
      if (mon_addr[i] !== AW'(i % 16 + (i >= 16 ? i - 16 - i % 16 : 0))
          || mon_data[i] !== exp_data(i < 16 ? i : i - 16)) begin
        errors++;
        $display("FAIL truncated_write%0d addr=%h data=%h required addr=%h data=%h",
                 i, mon_addr[i], mon_data[i], AW'(i < 16 ? i : i - 16),
                 exp_data(i < 16 ? i : i - 16));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    capture_en = 1'b1;
    clear_mon();
    vsync_pulse();
    drive_line(-1, 0, HI_LEN - 1);
    drive_line(0, 0, HI_LEN - 1);
    drive_line(1, 0, 5);
    checks++;
    if (vif.pix_we !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_before we=%b busy=%b required 1 1", vif.pix_we, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (vif.pix_we !== 1'b0 || vif.pix_waddr !== '0 || vif.pix_wdata !== 12'h000
        || busy !== 1'b0 || vif.frame_done !== 1'b0 || vif.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_clear we=%b waddr=%h wdata=%h busy=%b required all 0",
               vif.pix_we, vif.pix_waddr, vif.pix_wdata, busy);
    end
    drive_line(1, 6, 7);
    rst_n = 1'b1;
    clear_mon();
    drive_line(1, 8, HI_LEN - 1);
    for (int n = 3; n < VB + VA + 1; n++) drive_line(n - VB, 0, HI_LEN - 1);
    checks++;
    if (wr_cnt !== 0 || busy_cnt !== 0) begin
      errors++;
      $display("FAIL mid_reset_resume writes=%0d busy_cycles=%0d required 0 0", wr_cnt, busy_cnt);
    end
    drive_frame();
    checks++;
    if (wr_cnt !== 32 || done_cnt !== 1 || mon_addr[0] !== '0 || mon_data[31] !== exp_data(31)) begin
      errors++;
      $display("FAIL mid_reset_frame writes=%0d done=%0d first=%h last=%h required 32 1 0 %h",
               wr_cnt, done_cnt, mon_addr[0], mon_data[31], exp_data(31));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    capture_en = 1'b0;
    vif.vga_hsync = 1'b1;
    vif.vga_vsync = 1'b1;
    vif.vga_red = '0;
    vif.vga_green = '0;
    vif.vga_blue = '0;
    clear_mon();
    test_reset();
    test_full_frame();
    test_capture_disabled();
    test_late_enable();
    test_truncated_frame();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_frame_capture.md
# vga_frame_capture

Receive-side counterpart of the VGA pixel output path: samples a 4:4:4 VGA stream (RGB plus active-low hsync/vsync) in the pixel clock domain, finds the active window from sync edges and porch parameters, and repacks each active pixel into a 12-bit word {R,G,B} with a linear frame-buffer write address. Used for loopback checking of the display pipeline and for frame grabbing into on-chip RAM.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_BACK, 48, pixel clocks from hsync deassertion to first active pixel
- V_ACTIVE, 480, active lines per frame
- V_BACK, 33, lines from vsync deassertion to first active line
- ADDR_W, 19, write address width; must satisfy 2**ADDR_W >= H_ACTIVE*V_ACTIVE

- clk  in  1  pixel clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- capture_en  in  1  level; arms capture of whole frames
- vga_hsync  in  1  horizontal sync, active low
- vga_vsync  in  1  vertical sync, active low
- vga_red / vga_green / vga_blue  in  4 each  colour inputs
- pix_we  out  1  write strobe, one cycle per active pixel
- pix_waddr  out  ADDR_W  linear address y*H_ACTIVE + x
- pix_wdata  out  12  {red, green, blue}
- frame_done  out  1  one-cycle pulse with the last write of a frame
- frame_err  out  1  one-cycle pulse when a frame is truncated
- busy  out  1  high in CAPTURE

## Operation
- Input stage: all VGA inputs registered once; sync edges detected on registered values (previous-sample register). Inputs assumed synchronous to clk.
- Pixel index: 0 on the first sample with hsync high after low; +1 per clock; saturates at 2047 (11 bits), never wraps.
- Line index: cleared on vsync rising edge; line 0 begins at the first hsync rising edge strictly after it; +1 per hsync rising edge; saturates at 1023.
- Active sample: pixel index in [H_BACK, H_BACK+H_ACTIVE-1] and line index in [V_BACK, V_BACK+V_ACTIVE-1]. RGB outside this window ignored.
- FSM:
  - IDLE: no writes. capture_en=1 -> ARMED.
  - ARMED: no writes. vsync rising edge -> CAPTURE (address counter := 0). capture_en=0 -> IDLE.
  - CAPTURE: every active sample writes; address counter +1 per write. Last active sample of last active line: frame_done with that write; then ARMED if capture_en=1, else IDLE. capture_en falling mid-frame does not abort.
  - Vsync rising edge in CAPTURE before frame complete: frame_err pulse, no frame_done; treated as start of new frame (address := 0, stay CAPTURE) if capture_en=1, else IDLE.
- Lines with fewer than H_ACTIVE active samples (early hsync) write only the samples seen; address continues incrementing (no padding).
- Address counter never exceeds H_ACTIVE*V_ACTIVE-1 within a frame.

## Timing
- Reset: pix_we=0, pix_waddr=0, pix_wdata=0, frame_done=0, frame_err=0, busy=0, FSM IDLE, counters 0, sync history registers 1 (idle-high, no false edge after reset).
- Latency: input sampled at rising edge k appears on pix_we/pix_waddr/pix_wdata after edge k+1 (2-register path). All outputs registered.
- pix_waddr/pix_wdata hold last values when pix_we=0.
- busy rises the cycle after the vsync edge is detected, falls with frame_done's deassertion cycle.
- frame_done and frame_err are never asserted together.
- Reset asserted mid-frame: outputs clear immediately; capture resumes only via IDLE -> ARMED -> next vsync rising edge.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs 0; release with syncs high -> no pulses, busy=0.
- Small params (H_ACTIVE=8, H_BACK=2, V_ACTIVE=4, V_BACK=1), capture_en=1, one frame with RGB={x,y} pattern -> exactly 32 writes, addresses 0..31, wdata matches, frame_done once with addr 31, latency 2 edges.
- capture_en=0 over two full frames -> zero writes, busy=0.
- capture_en raised mid-active-region -> no writes until next vsync rise, then complete frame starting at addr 0.
- Vsync rise after 2 active lines -> frame_err one cycle, no frame_done; following full frame writes 0..31 and frame_done.
- rst_n pulsed low during line 2 -> outputs 0 same cycle; next capture begins only after a fresh vsync rising edge.
